seq_pattern_detector: RTL and testbench

- Parametrised successor to the team's fixed "three consecutive ones" Moore detector.
- Detects a runtime-programmable serial bit pattern of PAT_W bits on a 1-bit input stream, with a sample-enable qualifier.
- Supports overlapping and non-overlapping match modes, and keeps a saturating match counter.
- Used as a line/stream monitor in front of control logic. PATTERN=3'b111 with OVERLAP=1 reproduces the legacy detector's output.

---
 rtl/seq_det_pkg.sv | 12 +
 rtl/seq_pattern_detector_sat_counter.sv | 37 +++
 rtl/seq_pattern_detector.sv | 70 +++++++
 tb/tb_seq_pattern_detector.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared definitions for the serial pattern detector.
// FSM state encoding and the legacy default pattern.
package seq_det_pkg;

    typedef enum logic {
        S_FILL  = 1'b0,
        S_ARMED = 1'b1
    } state_t;

    localparam logic [2:0] PAT_LEGACY = 3'b111;

endpackage

// File: rtl/seq_pattern_detector_sat_counter.sv
// Saturating up-counter with synchronous clear.
// SAT is registered alongside CNT so it tracks the all-ones value.
module sat_counter
    import seq_det_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         CLR,
    input  logic         INC,
    output logic [W-1:0] CNT,
    output logic         SAT
);

    logic [W-1:0] cnt_n;

    always_comb begin
        cnt_n = CNT;
        if (CLR) begin
            cnt_n = '0;
        end else if (INC && (CNT != {W{1'b1}})) begin
            cnt_n = CNT + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            CNT <= '0;
            SAT <= 1'b0;
        end else begin
            CNT <= cnt_n;
            SAT <= &cnt_n;
        end
    end

endmodule

// File: rtl/seq_pattern_detector.sv
// Runtime-programmable serial pattern detector with enable,
// overlap/non-overlap modes and a saturating match counter.
module seq_pattern_detector
    import seq_det_pkg::*;
#(
    parameter int PAT_W = 3,
    parameter int CNT_W = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic             X,
    input  logic [PAT_W-1:0] PATTERN,
    input  logic             OVERLAP,
    input  logic             CLR_CNT,
    output logic             Y,
    output logic [CNT_W-1:0] MATCH_CNT,
    output logic             CNT_SAT
);

    localparam int FW = $clog2(PAT_W + 1);
    localparam logic [FW-1:0] FULL = FW'(PAT_W);

    logic [PAT_W-1:0] sr, sr_n, sr_nxt;
    logic [FW-1:0]    fill, fill_n, fill_nxt;
    logic             y_nxt;
    logic             hit;
    state_t           state;

    assign state = (fill == FULL) ? S_ARMED : S_FILL;

    always_comb begin
        sr_n     = {sr[PAT_W-2:0], X};
        fill_n   = (state == S_ARMED) ? FULL : fill + 1'b1;
        hit      = (fill_n == FULL) && (sr_n == PATTERN);
        sr_nxt   = sr;
        fill_nxt = fill;
        y_nxt    = Y;
        if (EN) begin
            sr_nxt   = sr_n;
            y_nxt    = hit;
            // Non-overlap mode restarts history but keeps the shifted bits
            fill_nxt = (hit && !OVERLAP) ? '0 : fill_n;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            sr   <= '0;
            fill <= '0;
            Y    <= 1'b0;
        end else begin
            sr   <= sr_nxt;
            fill <= fill_nxt;
            Y    <= y_nxt;
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_cnt (
        .CLK (CLK),
        .RST (RST),
        .CLR (CLR_CNT),
        .INC (EN && hit),
        .CNT (MATCH_CNT),
        .SAT (CNT_SAT)
    );

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Directed self-checking bench for seq_pattern_detector.
// Uses PAT_W=3, CNT_W=2 so saturation is reachable quickly.
module tb_seq_pattern_detector;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       EN = 1'b0;
    logic       X = 1'b0;
    logic [2:0] PATTERN = 3'b111;
    logic       OVERLAP = 1'b1;
    logic       CLR_CNT = 1'b0;
    logic       Y;
    logic [1:0] MATCH_CNT;
    logic       CNT_SAT;

    int n_tests = 0;
    int n_fail = 0;

    seq_pattern_detector #(
        .PAT_W (3),
        .CNT_W (2)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .EN        (EN),
        .X         (X),
        .PATTERN   (PATTERN),
        .OVERLAP   (OVERLAP),
        .CLR_CNT   (CLR_CNT),
        .Y         (Y),
        .MATCH_CNT (MATCH_CNT),
        .CNT_SAT   (CNT_SAT)
    );

    always #5 CLK = ~CLK;

    task automatic step(input logic e, input logic x);
        EN = e;
        X  = x;
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        EN  = 1'b0;
    endtask

    task automatic test_reset();
        EN = 1'b1;
        X = 1'b1;
        CLR_CNT = 1'b0;
        RST = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b0;
        EN = 1'b0;
        n_tests++;
        if (Y !== 1'b0 || MATCH_CNT !== 2'd0 || CNT_SAT !== 1'b0) begin
            $display("FAIL reset: got Y=%b cnt=%0d sat=%b want 0/0/0",
                     Y, MATCH_CNT, CNT_SAT);
            n_fail++;
        end
        // three 1s right after reset must be needed in full
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        n_tests++;
        if (Y !== 1'b0) begin
            $display("FAIL reset_fill: got Y=%b want 0", Y);
            n_fail++;
        end
    endtask

    task automatic test_legacy();
        bit xs [5];
        bit ys [5];
        xs = '{1, 1, 1, 1, 0};
        ys = '{0, 0, 1, 1, 0};
        PATTERN = 3'b111;
        OVERLAP = 1'b1;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(1'b1, xs[i]);
            n_tests++;
            if (Y !== ys[i]) begin
                $display("FAIL legacy_y[%0d]: got %b want %b", i, Y, ys[i]);
                n_fail++;
            end
        end
        n_tests++;
        if (MATCH_CNT !== 2'd2) begin
            $display("FAIL legacy_cnt: got %0d want 2", MATCH_CNT);
            n_fail++;
        end
    endtask

    task automatic test_non_overlap();
        bit ys [6];
        ys = '{0, 0, 1, 0, 0, 1};
        PATTERN = 3'b111;
        OVERLAP = 1'b0;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b1);
            n_tests++;
            if (Y !== ys[i]) begin
                $display("FAIL nonovl_y[%0d]: got %b want %b", i, Y, ys[i]);
                n_fail++;
            end
        end
        n_tests++;
        if (MATCH_CNT !== 2'd2) begin
            $display("FAIL nonovl_cnt: got %0d want 2", MATCH_CNT);
            n_fail++;
        end
    endtask

    task automatic test_pattern_101();
        bit xs [5];
        bit yo [5];
        bit yn [5];
        xs = '{1, 0, 1, 0, 1};
        yo = '{0, 0, 1, 0, 1};
        yn = '{0, 0, 1, 0, 0};
        PATTERN = 3'b101;
        OVERLAP = 1'b1;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(1'b1, xs[i]);
            n_tests++;
            if (Y !== yo[i]) begin
                $display("FAIL p101_ovl_y[%0d]: got %b want %b", i, Y, yo[i]);
                n_fail++;
            end
        end
        n_tests++;
        if (MATCH_CNT !== 2'd2) begin
            $display("FAIL p101_ovl_cnt: got %0d want 2", MATCH_CNT);
            n_fail++;
        end
        OVERLAP = 1'b0;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(1'b1, xs[i]);
            n_tests++;
            if (Y !== yn[i]) begin
                $display("FAIL p101_nov_y[%0d]: got %b want %b", i, Y, yn[i]);
                n_fail++;
            end
        end
        n_tests++;
        if (MATCH_CNT !== 2'd1) begin
            $display("FAIL p101_nov_cnt: got %0d want 1", MATCH_CNT);
            n_fail++;
        end
    endtask

    task automatic test_en_gating();
        PATTERN = 3'b111;
        OVERLAP = 1'b1;
        do_reset();
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0);
            n_tests++;
            if (Y !== 1'b0) begin
                $display("FAIL en_gap_y[%0d]: got %b want 0", i, Y);
                n_fail++;
            end
        end
        step(1'b1, 1'b1);
        n_tests++;
        if (Y !== 1'b1 || MATCH_CNT !== 2'd1) begin
            $display("FAIL en_hit: got Y=%b cnt=%0d want 1/1", Y, MATCH_CNT);
            n_fail++;
        end
        // Y must hold high through a gap after a hit
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b0);
            n_tests++;
            if (Y !== 1'b1 || MATCH_CNT !== 2'd1) begin
                $display("FAIL en_hold[%0d]: got Y=%b cnt=%0d want 1/1",
                         i, Y, MATCH_CNT);
                n_fail++;
            end
        end
    endtask

    task automatic test_reset_mid();
        PATTERN = 3'b111;
        OVERLAP = 1'b1;
        do_reset();
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        do_reset();
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b1);
            n_tests++;
            if (Y !== 1'b0) begin
                $display("FAIL rstmid_y[%0d]: got %b want 0", i, Y);
                n_fail++;
            end
        end
        step(1'b1, 1'b1);
        n_tests++;
        if (Y !== 1'b1) begin
            $display("FAIL rstmid_hit: got %b want 1", Y);
            n_fail++;
        end
    endtask

    task automatic test_saturation();
        PATTERN = 3'b111;
        OVERLAP = 1'b1;
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1);
        n_tests++;
        if (MATCH_CNT !== 2'd2 || CNT_SAT !== 1'b0) begin
            $display("FAIL sat_mid: got cnt=%0d sat=%b want 2/0",
                     MATCH_CNT, CNT_SAT);
            n_fail++;
        end
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
        n_tests++;
        if (MATCH_CNT !== 2'd3 || CNT_SAT !== 1'b1) begin
            $display("FAIL sat_full: got cnt=%0d sat=%b want 3/1",
                     MATCH_CNT, CNT_SAT);
            n_fail++;
        end
        CLR_CNT = 1'b1;
        step(1'b1, 1'b1);
        CLR_CNT = 1'b0;
        n_tests++;
        if (Y !== 1'b1 || MATCH_CNT !== 2'd0 || CNT_SAT !== 1'b0) begin
            $display("FAIL clr_on_hit: got Y=%b cnt=%0d sat=%b want 1/0/0",
                     Y, MATCH_CNT, CNT_SAT);
            n_fail++;
        end
        step(1'b1, 1'b1);
        n_tests++;
        if (MATCH_CNT !== 2'd1) begin
            $display("FAIL after_clr: got %0d want 1", MATCH_CNT);
            n_fail++;
        end
    endtask

    initial begin
        test_reset();
        test_legacy();
        test_non_overlap();
        test_pattern_101();
        test_en_gating();
        test_reset_mid();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
